fir_mac_sequencer: RTL and testbench

Control and data-staging block for one FIR channel. It feeds the registered multiplier and adder from the operand side and collects the accumulated sum from the result side. It accepts one input sample per handshake, shifts it into a TAPS-deep delay line, and issues one (sample, coefficient) pair per cycle to the multiplier. It steers the adder's accumulator input so partial products are summed, then presents the 32-bit sum and a scaled, saturated 16-bit output on a valid/ready port.

---
 rtl/fir_mac_sequencer_pkg.sv | 25 ++
 rtl/fir_mac_sequencer_tap_bank.sv | 44 ++++
 rtl/fir_mac_sequencer.sv | 112 +++++++++++
 tb/tb_fir_mac_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types and constants for the FIR MAC sequencer and its tap bank.
package fir_pkg;

  localparam int DATA_W    = 16;
  localparam int ACC_W     = 32;
  localparam int MUL_LAT   = 1;
  localparam int ADD_LAT   = 1;
  localparam int DRAIN_LEN = MUL_LAT + ADD_LAT;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;

  // Clamp an unsigned accumulator value into the 16-bit output range.
  function automatic logic [DATA_W-1:0] sat_u16(input logic [ACC_W-1:0] v);
    if (v > ACC_W'({DATA_W{1'b1}}))
      return {DATA_W{1'b1}};
    else
      return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_tap_bank.sv
// Sample delay line and coefficient register file, both read at the same tap index.
module fir_tap_bank
  import fir_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] shift_data,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_wdata,
  input  logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_sample,
  output logic [DATA_W-1:0] rd_coef
);

  logic [DATA_W-1:0] x_q    [TAPS];
  logic [DATA_W-1:0] coef_q [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (shift_en) begin
        x_q[0] <= shift_data;
        for (int i = 1; i < TAPS; i++)
          x_q[i] <= x_q[i-1];
      end
      // Addresses beyond the last tap are ignored when TAPS is not a power of two.
      if (coef_we && (32'(coef_addr) < TAPS))
        coef_q[coef_addr] <= coef_wdata;
    end
  end

  assign rd_sample = x_q[rd_idx];
  assign rd_coef   = coef_q[rd_idx];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one FIR channel through an external registered multiplier/adder pair.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS      = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [DATA_W-1:0]        coef_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ACC_W-1:0]         out_acc,
  output logic                     busy,
  output logic [DATA_W-1:0]        mac_a,
  output logic [DATA_W-1:0]        mac_b,
  output logic [ACC_W-1:0]         mac_acc_in,
  input  logic [ACC_W-1:0]         mac_mult_result,
  input  logic [ACC_W-1:0]         mac_acc_out
);

  localparam int AW = $clog2(TAPS);
  localparam int DW = $clog2(DRAIN_LEN + 1);

  state_t            state;
  logic [AW-1:0]     k;
  logic [DW-1:0]     drain_cnt;
  logic [ACC_W-1:0]  out_acc_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] rd_sample;
  logic [DATA_W-1:0] rd_coef;
  logic              accept;
  logic              acc_en;

  assign accept = in_valid && (state == IDLE);

  fir_tap_bank #(.TAPS(TAPS), .AW(AW)) u_tap_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (accept),
    .shift_data (in_data),
    .coef_we    (coef_we && (state == IDLE)),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .rd_idx     (k),
    .rd_sample  (rd_sample),
    .rd_coef    (rd_coef)
  );

  // The output register is loaded on the last drain cycle, when the adder holds the full sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      drain_cnt  <= '0;
      out_acc_q  <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ISSUE;
            k     <= '0;
          end
        end
        ISSUE: begin
          if (k == AW'(TAPS - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            k <= k + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(DRAIN_LEN - 1)) begin
            out_acc_q  <= mac_acc_out;
            out_data_q <= sat_u16(mac_acc_out >> OUT_SHIFT);
            state      <= OUT;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        OUT: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Products p1..p(TAPS-1) land during ISSUE k>=2 and the first drain cycle; p0 starts from zero.
  assign acc_en = ((state == ISSUE) && (32'(k) >= 2)) ||
                  ((state == DRAIN) && (drain_cnt == '0));

  assign mac_acc_in = acc_en ? mac_acc_out : '0;
  assign mac_a      = (state == ISSUE) ? rd_sample : '0;
  assign mac_b      = (state == ISSUE) ? rd_coef   : '0;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_acc   = out_acc_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer with a behavioural registered multiplier/adder.
module tb_fir_mac_sequencer;

  localparam int TAPS = 8;
  localparam int LAT  = TAPS + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [31:0] out_acc;
  logic        busy;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_acc_in;
  logic [31:0] mac_mult_result = '0;
  logic [31:0] mac_acc_out     = '0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          cycle_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          accept_cnt = 0;
  int          last_accept_edge = 0;
  int          last_hs_edge = 0;
  logic        prev_valid = 1'b0;

  fir_mac_sequencer #(.TAPS(TAPS), .OUT_SHIFT(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .coef_we         (coef_we),
    .coef_addr       (coef_addr),
    .coef_wdata      (coef_wdata),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_acc         (out_acc),
    .busy            (busy),
    .mac_a           (mac_a),
    .mac_b           (mac_b),
    .mac_acc_in      (mac_acc_in),
    .mac_mult_result (mac_mult_result),
    .mac_acc_out     (mac_acc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle_cnt       <= cycle_cnt + 1;
    mac_mult_result <= 32'(mac_a) * 32'(mac_b);
    mac_acc_out     <= mac_mult_result + mac_acc_in;
  end

  function automatic logic [15:0] expSat(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [31:0] exp, input bit track);
    int n;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: sample %0d never accepted", d);
      in_valid = 1'b0;
      return;
    end
    last_accept_edge = cycle_cnt + 1;
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(last_accept_edge);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic writeCoef(input logic [2:0] a, input logic [15:0] v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic setAllCoefs(input logic [15:0] v);
    for (int i = 0; i < TAPS; i++)
      writeCoef(3'(i), v);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d results still pending, busy=%0b", exp_q.size(), busy);
    end
  endtask

  // Monitor: latency is checked when out_valid rises, data when the handshake is seen.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (in_valid && in_ready)
          accept_cnt++;
        if (out_valid && !prev_valid) begin
          if (lat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_output: out_acc=%0d with nothing expected", out_acc);
          end else begin
            checkOutput("latency", 32'(cycle_cnt - lat_q.pop_front()), 32'(LAT));
          end
        end
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("out_acc", out_acc, e);
          checkOutput("out_data", 32'(out_data), 32'(expSat(e)));
          last_hs_edge = cycle_cnt + 1;
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int imp[8];
    int base;
    int n;
    imp = '{10, 7, 5, 3, 2, 1, 1, 1};
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_acc", out_acc, 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_mac_a", 32'(mac_a), 32'd0);
    checkOutput("rst_mac_b", 32'(mac_b), 32'd0);
    checkOutput("rst_mac_acc_in", mac_acc_in, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] running sum");
    setAllCoefs(16'd1);
    applyStimulus(16'd1, 32'd1, 1'b1);
    applyStimulus(16'd2, 32'd3, 1'b1);
    applyStimulus(16'd3, 32'd6, 1'b1);
    waitDrain();

    $display("[TB] impulse");
    doReset();
    for (int i = 0; i < TAPS; i++)
      writeCoef(3'(i), 16'(imp[i]));
    applyStimulus(16'd1, 32'(imp[0]), 1'b1);
    for (int j = 1; j < TAPS; j++)
      applyStimulus(16'd0, 32'(imp[j]), 1'b1);
    waitDrain();

    $display("[TB] backpressure");
    doReset();
    setAllCoefs(16'd1);
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(16'd5, 32'd5, 1'b1);
    base = accept_cnt;
    fork
      applyStimulus(16'd6, 32'd11, 1'b1);
    join_none
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      #1;
      checkOutput("bp_out_data_stable", 32'(out_data), 32'd5);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    checkOutput("bp_no_extra_accept", 32'(accept_cnt - base), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    wait fork;
    checkOutput("bp_accept_after_hs", 32'(last_accept_edge), 32'(last_hs_edge + 1));
    waitDrain();

    $display("[TB] saturation");
    doReset();
    setAllCoefs(16'd1024);
    for (int s = 1; s <= TAPS; s++)
      applyStimulus(16'd2048, 32'(2097152 * s), 1'b1);
    waitDrain();

    $display("[TB] write while busy and reset mid-issue");
    doReset();
    for (int i = 0; i < TAPS; i++)
      writeCoef(3'(i), 16'(imp[i]));
    applyStimulus(16'd1, 32'd10, 1'b1);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'd99;
    @(negedge clk);
    coef_we = 1'b0;
    applyStimulus(16'd0, 32'd7, 1'b1);
    waitDrain();
    applyStimulus(16'd1, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_mac_a", 32'(mac_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'd1, 32'd0, 1'b1);
    waitDrain();
    setAllCoefs(16'd1);
    applyStimulus(16'd0, 32'd1, 1'b1);
    waitDrain();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
